// File: rtl/registrador_if.sv
// Bus bundle for registrador: data, load strobe, write enable and held output.
// The strobe is named clk for legacy compatibility; it is a level signal, not a clock.
interface registrador_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] d;
    logic             clk;
    logic             escreve;
    logic [WIDTH-1:0] q;

    modport master (
        output d,
        output clk,
        output escreve,
        input  q
    );

    modport slave (
        input  d,
        input  clk,
        input  escreve,
        output q
    );
endinterface

// File: rtl/registrador.sv
// Data register loaded on a rising edge of a sampled strobe when the write enable is high.
// Define REGISTRADOR_SYNC_EN to add a 2-flop strobe synchronizer with matching d/escreve delay.
module registrador #(
    parameter int WIDTH = 8
) (
    input  logic          clkSimulation,
    input  logic          rst,
    registrador_if.slave  bus
);

    logic             clk_s;
    logic             clk_prev;
    logic             rise;
    logic [WIDTH-1:0] d_al;
    logic             esc_al;
    logic [WIDTH-1:0] q_reg;

`ifdef REGISTRADOR_SYNC_EN
    logic             clk_p0;
    logic             clk_p1;
    logic             vld_p0;
    logic             vld_p1;
    logic [WIDTH-1:0] d_p0;
    logic [WIDTH-1:0] d_p1;

    // Stage p0/p1: strobe synchronizer, enable delayed alongside it
    always_ff @(posedge clkSimulation) begin
        if (!rst) begin
            clk_p0 <= 1'b0;
            clk_p1 <= 1'b0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            clk_p0 <= bus.clk;
            clk_p1 <= clk_p0;
            vld_p0 <= bus.escreve;
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clkSimulation) begin
        d_p0 <= bus.d;
        d_p1 <= d_p0;
    end

    assign clk_s  = clk_p1;
    assign d_al   = d_p1;
    assign esc_al = vld_p1;
`else
    assign clk_s  = bus.clk;
    assign d_al   = bus.d;
    assign esc_al = bus.escreve;
`endif

    assign rise = clk_s & ~clk_prev;

    // Output stage: clk_prev resets high so a strobe already high at release is not an edge
    always_ff @(posedge clkSimulation) begin
        if (!rst) begin
            q_reg    <= '0;
            clk_prev <= 1'b1;
        end else begin
            clk_prev <= clk_s;
            if (rise && esc_al) begin
                q_reg <= d_al;
            end
        end
    end

    assign bus.q = q_reg;

endmodule

// File: tb/tb_registrador.sv
// Directed bench for registrador (default build): each step queues the expected q and checks it after the edge.
module tb_registrador;

    localparam int WIDTH = 8;

    logic clkSimulation;
    logic rst;

    registrador_if #(.WIDTH(WIDTH)) bus ();

    registrador #(.WIDTH(WIDTH)) dut (
        .clkSimulation (clkSimulation),
        .rst           (rst),
        .bus           (bus.slave)
    );

    initial clkSimulation = 1'b0;
    always #5 clkSimulation = ~clkSimulation;

    logic [WIDTH-1:0] exp_q[$];
    int checks;
    int fails;

    task automatic step(input logic r, input logic [WIDTH-1:0] dv, input logic s,
                        input logic e, input logic [WIDTH-1:0] expv, input string tag);
        logic [WIDTH-1:0] want;
        rst         = r;
        bus.d       = dv;
        bus.clk     = s;
        bus.escreve = e;
        exp_q.push_back(expv);
        @(posedge clkSimulation);
        #1;
        want = exp_q.pop_front();
        checks++;
        assert (bus.q === want)
        else begin
            fails++;
            $error("FAIL %s: q=%h expected %h", tag, bus.q, want);
        end
    endtask

    initial begin
        checks      = 0;
        fails       = 0;
        rst         = 1'b0;
        bus.d       = '0;
        bus.clk     = 1'b0;
        bus.escreve = 1'b0;
        #2;

        step(1'b0, 8'hFF, 1'b1, 1'b1, 8'h00, "reset_a");
        step(1'b0, 8'hFF, 1'b0, 1'b1, 8'h00, "reset_b");
        step(1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, "release_low");

        step(1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, "basic_load");
        step(1'b1, 8'h3C, 1'b1, 1'b1, 8'hA5, "held_high_a");
        step(1'b1, 8'h3C, 1'b1, 1'b1, 8'hA5, "held_high_b");
        step(1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, "strobe_low");

        step(1'b1, 8'h5A, 1'b1, 1'b0, 8'hA5, "gate_rise");
        step(1'b1, 8'h5A, 1'b1, 1'b1, 8'hA5, "gate_late_en");
        step(1'b1, 8'h5A, 1'b1, 1'b1, 8'hA5, "gate_held");
        step(1'b1, 8'h5A, 1'b0, 1'b1, 8'hA5, "no_deferred");
        step(1'b1, 8'h99, 1'b0, 1'b1, 8'hA5, "en_no_edge");

        step(1'b1, 8'h01, 1'b1, 1'b1, 8'h01, "b2b_1");
        step(1'b1, 8'hEE, 1'b0, 1'b1, 8'h01, "b2b_1_low");
        step(1'b1, 8'h02, 1'b1, 1'b1, 8'h02, "b2b_2");
        step(1'b1, 8'hEE, 1'b0, 1'b1, 8'h02, "b2b_2_low");
        step(1'b1, 8'h03, 1'b1, 1'b1, 8'h03, "b2b_3");
        step(1'b1, 8'hEE, 1'b0, 1'b1, 8'h03, "b2b_3_low");

        step(1'b0, 8'h77, 1'b1, 1'b1, 8'h00, "rr_reset");
        step(1'b1, 8'h77, 1'b1, 1'b1, 8'h00, "rr_release_high");
        step(1'b1, 8'h77, 1'b1, 1'b1, 8'h00, "rr_still_high");
        step(1'b1, 8'h77, 1'b0, 1'b1, 8'h00, "rr_low");
        step(1'b1, 8'h77, 1'b1, 1'b1, 8'h77, "rr_load");

        step(1'b1, 8'h77, 1'b0, 1'b1, 8'h77, "mid_low");
        step(1'b1, 8'hC3, 1'b1, 1'b1, 8'hC3, "mid_load_c3");
        step(1'b1, 8'hC3, 1'b0, 1'b1, 8'hC3, "mid_low_2");
        step(1'b0, 8'h11, 1'b1, 1'b1, 8'h00, "mid_reset_wins");
        step(1'b1, 8'h11, 1'b1, 1'b1, 8'h00, "mid_release_high");
        step(1'b1, 8'h11, 1'b0, 1'b1, 8'h00, "mid_low_3");
        step(1'b1, 8'h11, 1'b1, 1'b1, 8'h11, "mid_resume");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/registrador.md
# registrador

Parameterised data register with write enable and a strobe-qualified load, clocked by the system clock `clkSimulation`. The `clk` input is not a clock: it is a load strobe sampled in the `clkSimulation` domain, and its rising transitions are edge-detected. `q` captures `d` on a detected strobe rising edge when `escreve` is high. The block sits between a stimulus or data source and downstream logic that needs a held byte.

## Interface
- `WIDTH`, default 8: data width of `d` and `q`.

- `clkSimulation`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  reset, synchronous, active-low.
- `d`  input  WIDTH  data to be loaded.
- `clk`  input  1  load strobe, level signal; only its rising transitions matter.
- `escreve`  input  1  write enable, active-high.
- `q`  output  WIDTH  registered data, driven directly from a flop.

## Operation
- Strobe history flop `clk_prev` holds the previous sampled strobe.
- Strobe edge: `rise = clk_s & ~clk_prev`, where `clk_s` is the sampled strobe (see Configuration).
- On each `clkSimulation` rising edge:
  - If `rst` = 0: `q` <= 0; `clk_prev` <= 1; synchronizer flops <= 0.
  - Otherwise, `clk_prev` <= `clk_s`.
  - If `rise` and the aligned `escreve` = 1, `q` <= aligned `d`.
  - Otherwise `q` holds.
- Strobe held high across many cycles gives a single load. A new load needs low then high again.
- Rising strobe edge with `escreve` = 0 is consumed: no load, and no deferred load later.
- `escreve` high without a strobe edge: no load.
- `d` changing while no edge is present has no effect on `q`.
- Reset wins over a simultaneous load.
- `clk_prev` resets to 1, so a strobe already high at reset release is not an edge. The strobe must go low first.
- Reset mid-operation clears `q` to 0 at that edge. Operation resumes on the first edge with `rst` = 1.

## Timing
- Reset value: `q` = 0, one cycle after sampling `rst` = 0 (synchronous).
- Without the macro, latency is 1 edge. `q` shows `d` right after the first `clkSimulation` rising edge where `clk` = 1, the previous sample was 0, and `escreve` = 1. `d` and `escreve` are sampled at that same edge.
- With the macro, latency is 3 edges from the strobe rising at the input to `q` updating. `d` and `escreve` pass through an equal-depth delay, so the data loaded is the value present when the strobe was first sampled high.
- Maximum load rate: one load per 2 `clkSimulation` cycles (strobe high 1 cycle, low 1 cycle).
- No combinational path from any input to `q`.

## Configuration
- Macro: `REGISTRADOR_SYNC_EN`.
- Defined:
  - `clk` passes through a 2-flop synchronizer before edge detection; `clk_s` is the second flop.
  - `d` and `escreve` are delayed 2 cycles to stay aligned with `clk_s`.
  - Total latency 3 edges.
  - Use when the strobe is asynchronous to `clkSimulation`.
- Undefined:
  - `clk_s` = `clk` directly; no delay flops on `d` or `escreve`.
  - Latency 1 edge.
  - The strobe must be synchronous to `clkSimulation`.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles with `d` = 8'hFF, `clk` toggling, `escreve` = 1 -> `q` = 8'h00 throughout.
- Basic load: `escreve` = 1, `d` = 8'hA5, strobe 0->1 -> `q` = 8'hA5 after 1 edge (3 with macro), and stays there while strobe stays high and `d` changes to 8'h3C.
- Enable gating: `escreve` = 0, `d` = 8'h5A, strobe 0->1 -> `q` unchanged (8'hA5). Raise `escreve` with strobe still high -> still no load.
- Back-to-back: alternate strobe 1/0 each cycle with `escreve` = 1 and `d` = 8'h01, 8'h02, 8'h03 on the high cycles -> `q` steps 8'h01, 8'h02, 8'h03.
- Reset release with strobe high: `rst` 0->1 while `clk` = 1, `d` = 8'h77, `escreve` = 1 -> `q` stays 8'h00 until strobe goes low then high, then `q` = 8'h77.
- Mid-operation reset: `q` = 8'hC3, assert `rst` = 0 on the same edge as a strobe rise with `d` = 8'h11 -> `q` = 8'h00; no load.
